// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, line levels and bit-timing helper for the UART TX drain stage.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit-period counter; tick pulses on the last cycle of each bit.
module uart_baud_gen #(
  parameter int ClksPerBit = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Terminal count wraps straight to zero so consecutive bits are exactly ClksPerBit long.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CntW'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops a synchronous FIFO and serialises each byte as an 8N1 UART frame.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int ClkFreq   = 100000000,
  parameter int BaudRate  = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifoEmpty,
  input  logic [DataWidth-1:0] fifoRdData,
  output logic                 fifoRdEn,
  output logic                 txd,
  output logic                 busy
);

  localparam int ClksPerBit = clks_per_bit(ClkFreq, BaudRate);
  localparam int IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DataWidth - 1);

  uart_state_e          state_q, state_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 txd_q, txd_d;
  logic                 pop;
  logic                 baud_clear;
  logic                 baud_tick;

  // The bit timer only runs while a frame is on the wire.
  assign baud_clear = (state_q == IDLE) || (state_q == LOAD);

  uart_baud_gen #(
    .ClksPerBit(ClksPerBit)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = (state_q == LOAD) ? ^fifoRdData : parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        // Gating with rst keeps the pop strobe quiet while reset is held.
        if (!fifoEmpty && rst) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d   = fifoRdData;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so txd_q lines up with state_q.
    case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      STOP:    txd_d = STOP_BIT;
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

  assign fifoRdEn = pop;
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE) || pop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed and random checks of fifo_uart_tx against a FIFO model and UART receiver.
module tb_fifo_uart_tx;

  localparam int ClkFreq = 1000000;
  localparam int BaudRate = 100000;
  localparam int Cpb = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int FrameClks = NBits * Cpb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] rd_data = 8'h00;
  logic       rd_en;
  logic       txd;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DataWidth(8),
    .ClkFreq  (ClkFreq),
    .BaudRate (BaudRate)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifoEmpty (fifo_empty),
    .fifoRdData(rd_data),
    .fifoRdEn  (rd_en),
    .txd       (txd),
    .busy      (busy)
  );

  // FIFO model with one-cycle read latency
  logic [7:0] mem[0:255];
  int push_cnt = 0;
  int pop_cnt = 0;
  int underflows = 0;

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (rd_en) begin
      if (fifo_empty) begin
        underflows = underflows + 1;
      end else begin
        rd_data <= mem[pop_cnt % 256];
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[push_cnt % 256] = b;
    push_cnt = push_cnt + 1;
  endtask

  // UART receiver model, mid-bit sampling
  logic [7:0] rx_q[$];
  logic [7:0] rx_v;
  int rx_errs = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && txd === 1'b0) begin
        repeat (Cpb / 2) @(negedge clk);
        #1;
        if (txd !== 1'b0) rx_errs = rx_errs + 1;
        for (int k = 0; k < 8; k++) begin
          repeat (Cpb) @(negedge clk);
          #1;
          rx_v[k] = txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (Cpb) @(negedge clk);
        #1;
        if (txd !== ^rx_v) rx_errs = rx_errs + 1;
`endif
        repeat (Cpb) @(negedge clk);
        #1;
        if (txd !== 1'b1) rx_errs = rx_errs + 1;
        rx_q.push_back(rx_v);
      end
    end
  end

  logic tx_log[0:1023];
  logic busy_log[0:1023];
  logic rden_log[0:1023];

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      tx_log[i] = txd;
      busy_log[i] = busy;
      rden_log[i] = rd_en;
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NBits == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %b expected 0", rd_en); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int busy_cnt;
    @(negedge clk);
    push(8'hA5);
    #1;
    n_checks++;
    if (rd_en !== 1'b1) begin n_fail++; $display("FAIL single_pop: got %b expected 1", rd_en); end
    record(FrameClks + 2);
    n_checks++;
    if (rden_log[0] !== 1'b0) begin n_fail++; $display("FAIL single_pop_width: got %b expected 0", rden_log[0]); end
    n_checks++;
    if (tx_log[0] !== 1'b1) begin n_fail++; $display("FAIL single_load_txd: got %b expected 1", tx_log[0]); end
    for (int k = 0; k < NBits; k++) begin
      for (int c = 0; c < Cpb; c++) begin
        n_checks++;
        if (tx_log[1 + k * Cpb + c] !== exp_bit(8'hA5, k)) begin
          n_fail++;
          $display("FAIL single_txd bit %0d cyc %0d: got %b expected %b", k, c, tx_log[1 + k * Cpb + c], exp_bit(8'hA5, k));
        end
      end
    end
    busy_cnt = 1;
    for (int i = 0; i < FrameClks + 2; i++) busy_cnt += int'(busy_log[i]);
    n_checks++;
    if (busy_cnt != FrameClks + 2) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, FrameClks + 2); end
    n_checks++;
    if (busy_log[FrameClks + 1] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy_log[FrameClks + 1]); end
  endtask

  task automatic test_back_to_back();
    int gap;
    int pops;
    int b1;
    @(negedge clk);
    push(8'h00);
    push(8'hFF);
    #1;
    n_checks++;
    if (rd_en !== 1'b1) begin n_fail++; $display("FAIL b2b_pop: got %b expected 1", rd_en); end
    record(2 * FrameClks + 5);
    b1 = FrameClks + 3;
    for (int k = 0; k < NBits; k++) begin
      for (int c = 0; c < Cpb; c++) begin
        n_checks++;
        if (tx_log[1 + k * Cpb + c] !== exp_bit(8'h00, k)) begin
          n_fail++;
          $display("FAIL b2b_txd0 bit %0d cyc %0d: got %b expected %b", k, c, tx_log[1 + k * Cpb + c], exp_bit(8'h00, k));
        end
        n_checks++;
        if (tx_log[b1 + k * Cpb + c] !== exp_bit(8'hFF, k)) begin
          n_fail++;
          $display("FAIL b2b_txd1 bit %0d cyc %0d: got %b expected %b", k, c, tx_log[b1 + k * Cpb + c], exp_bit(8'hFF, k));
        end
      end
    end
    gap = 0;
    for (int i = FrameClks + 1; i < 2 * FrameClks + 5 && tx_log[i] === 1'b1; i++) gap++;
    n_checks++;
    if (gap != 2) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 2", gap); end
    pops = 0;
    for (int i = 0; i < 2 * FrameClks + 5; i++) pops += int'(rden_log[i]);
    n_checks++;
    if (pops != 1 || rden_log[FrameClks + 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_pop: got %0d pops (at gap %b) expected 1 (1)", pops, rden_log[FrameClks + 1]);
    end
    n_checks++;
    if (rden_log[2 * FrameClks + 4] !== 1'b0 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drained: got rden %b empty %b expected 0 1", rden_log[2 * FrameClks + 4], fifo_empty);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    push(8'h5A);
    record(46);
    n_checks++;
    if (tx_log[45] !== 1'b1 || busy_log[45] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_bit3: got txd %b busy %b expected 1 1", tx_log[45], busy_log[45]);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b expected 1", txd); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    push(8'hC3);
    #1;
    n_checks++;
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_pop_in_reset: got %b expected 0", rd_en); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rd_en !== 1'b1) begin n_fail++; $display("FAIL midrst_repop: got %b expected 1", rd_en); end
    record(FrameClks + 2);
    for (int k = 0; k < NBits; k++) begin
      for (int c = 0; c < Cpb; c++) begin
        n_checks++;
        if (tx_log[1 + k * Cpb + c] !== exp_bit(8'hC3, k)) begin
          n_fail++;
          $display("FAIL midrst_txd bit %0d cyc %0d: got %b expected %b", k, c, tx_log[1 + k * Cpb + c], exp_bit(8'hC3, k));
        end
      end
    end
  endtask

  task automatic test_empty();
    int bad_txd = 0;
    int bad_busy = 0;
    int bad_rden = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (txd !== 1'b1) bad_txd++;
      if (busy !== 1'b0) bad_busy++;
      if (rd_en !== 1'b0) bad_rden++;
    end
    n_checks++;
    if (bad_txd != 0) begin n_fail++; $display("FAIL empty_txd: got %0d non-idle cycles expected 0", bad_txd); end
    n_checks++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL empty_busy: got %0d busy cycles expected 0", bad_busy); end
    n_checks++;
    if (bad_rden != 0) begin n_fail++; $display("FAIL empty_rden: got %0d pop cycles expected 0", bad_rden); end
  endtask

  task automatic test_random();
    logic [7:0] sent[64];
    int guard;
    rx_q.delete();
    rx_errs = 0;
    for (int i = 0; i < 64; i++) begin
      sent[i] = (i == 0) ? 8'h07 : 8'($urandom_range(0, 255));
      @(negedge clk);
      repeat ($urandom_range(0, 150)) @(negedge clk);
      push(sent[i]);
    end
    guard = 0;
    while (rx_q.size() < 64 && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (rx_q.size() != 64) begin n_fail++; $display("FAIL rand_count: got %0d bytes expected 64", rx_q.size()); end
    for (int i = 0; i < 64 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== sent[i]) begin n_fail++; $display("FAIL rand_byte %0d: got %02h expected %02h", i, rx_q[i], sent[i]); end
    end
    n_checks++;
    if (rx_errs != 0) begin n_fail++; $display("FAIL rand_framing: got %0d errors expected 0", rx_errs); end
    n_checks++;
    if (underflows != 0) begin n_fail++; $display("FAIL underflow: got %0d pops while empty expected 0", underflows); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_empty();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the team's synchronous FIFO: pops bytes whenever the FIFO is non-empty and serialises each one as an 8N1 UART frame on `txd`.
- Sits between the FIFO read port (`rdEn`/`rdData`/`empty`) and the board TX pin.
- The FIFO has one-cycle read latency: data appears on `rdData` the cycle after `rdEn`.

Parameters:
- DataWidth, 8, bits per character; must match the FIFO `DataWidth`.
- ClkFreq, 100000000, clock frequency in Hz.
- BaudRate, 115200, line rate in baud.
- ClksPerBit, derived localparam = ClkFreq/BaudRate (integer division); must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-low (0 = reset asserted).
- fifoEmpty  in  1  FIFO `empty` flag.
- fifoRdData  in  DataWidth  FIFO `rdData`; valid the cycle after `fifoRdEn`.
- fifoRdEn  out  1  FIFO `rdEn`; single-cycle pop strobe.
- txd  out  1  serial output; idle level is high.
- busy  out  1  high from pop until the end of the stop bit.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, fifoRdEn = 0, txd = 1, busy = 0.
  - Baud counter, bit index and shift register are cleared.
  - Reset asserted mid-frame truncates the frame immediately; txd returns high in the same instant.
- States: IDLE, LOAD, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE:
  - If fifoEmpty = 0: drive fifoRdEn = 1 for exactly one cycle and go to LOAD, with busy = 1.
  - Else remain in IDLE with fifoRdEn = 0.
- LOAD (1 cycle): capture fifoRdData into the shift register, clear the baud counter, go to START.
- START: txd = 0 for ClksPerBit cycles, then go to DATA with bit index = 0.
- DATA:
  - txd = shift[0], LSB first.
  - Each bit is held for ClksPerBit cycles, then the register shifts right and the index increments.
  - After bit DataWidth-1, go to STOP.
- STOP: txd = 1 for ClksPerBit cycles, then go to IDLE with busy = 0.
- Baud counter:
  - Width $clog2(ClksPerBit); counts 0 .. ClksPerBit-1.
  - The terminal count advances the bit; it wraps to 0 with no skipped cycle.
- txd is driven from a register (glitch-free); it changes only on state or bit boundaries.
- Back-to-back traffic: the STOP→IDLE→LOAD path inserts exactly 2 extra high clocks between frames, so the frame period is (DataWidth+2)·ClksPerBit + 2 clocks.
- fifoRdEn is never asserted outside IDLE and never while fifoEmpty = 1, so no underflow pops occur.
- fifoEmpty toggling mid-frame has no effect on the current frame.
- Data written to the FIFO while busy is sent in FIFO order after the current frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives txd = XOR of the captured byte (even parity) for ClksPerBit cycles.
  - Frame becomes 8E1; the frame period grows by ClksPerBit.
- Undefined: no PARITY state and no parity logic; the frame is 8N1.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, LOAD, START, DATA, PARITY, STOP).
  - Localparams: START_BIT = 0, STOP_BIT = 1, IDLE_LEVEL = 1.
  - Function clks_per_bit(ClkFreq, BaudRate).
- Sub-module uart_baud_gen:
  - Parameter ClksPerBit; inputs clk, rst, clear.
  - Output tick: a 1-cycle pulse every ClksPerBit cycles.
  - The FSM advances on tick.

Test Plan (ClkFreq = 1000000, BaudRate = 100000, so ClksPerBit = 10):
- Single byte: FIFO holds 0xA5.
  - fifoRdEn is high for 1 cycle; LOAD follows.
  - txd = 0, 1,0,1,0,0,1,0,1, 1, each level 10 clocks.
  - busy = 1 for 2 + 100 clocks.
- Back-to-back: FIFO holds 0x00 then 0xFF.
  - Frames for both bytes; exactly 2 high clocks between the 0x00 stop bit and the 0xFF start bit.
  - After the second frame, fifoRdEn = 0 with fifoEmpty = 1.
- Empty FIFO: fifoEmpty held at 1 for 500 cycles → fifoRdEn = 0, txd = 1, busy = 0 throughout.
- Reset mid-frame: rst = 0 during bit 3 of 0x5A.
  - txd = 1 and busy = 0 asynchronously.
  - After release with the FIFO non-empty, the next pop starts a fresh full frame.
- Parity build (UART_TX_PARITY_EN):
  - 0x07: parity bit = 1.
  - 0xA5: parity bit = 0.
  - Frame length = 110 clocks.
- Randomised: 64 random bytes pushed at random times → a UART receiver model recovers an identical sequence; no pop while fifoEmpty = 1.
